// File: rtl/instr_adder_sklansky_wrap_if.sv
// Logic-analyser bus between the SoC and the instrumented adder wrapper.
// The SoC (master) drives the three LA input words and samples the three LA output words.
interface instr_adder_sklansky_wrap_if;
    logic [31:0] la1_data_in;
    logic [31:0] la2_data_in;
    logic [31:0] la3_data_in;
    logic [31:0] la1_data_out;
    logic [31:0] la2_data_out;
    logic [31:0] la3_data_out;

    modport master (
        output la1_data_in, la2_data_in, la3_data_in,
        input  la1_data_out, la2_data_out, la3_data_out
    );

    modport slave (
        input  la1_data_in, la2_data_in, la3_data_in,
        output la1_data_out, la2_data_out, la3_data_out
    );
endinterface

// File: rtl/instr_adder_sklansky_wrap.sv
// 32-bit Sklansky prefix adder wrapped as a clocked ring oscillator test structure.
// A selected sum bit is inverted back into an operand bit, and its rising edges are counted.
module instr_adder_sklansky_wrap (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        active,
    input  logic [31:0] la1_data_in,
    input  logic [31:0] la2_data_in,
    input  logic [31:0] la3_data_in,
    input  logic [31:0] la1_oenb,
    input  logic [31:0] la2_oenb,
    input  logic [31:0] la3_oenb,
    input  logic [37:0] io_in,
    output logic [31:0] la1_data_out,
    output logic [31:0] la2_data_out,
    output logic [31:0] la3_data_out,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    logic        ring_en;
    logic        cnt_en;
    logic        cnt_clr;
    logic        load;
    logic [4:0]  ring_sel;
    logic [4:0]  out_sel;

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        chain_prev_q;
    logic [31:0] cnt_q, cnt_d;

    logic        chain_out;
    logic [31:0] a_eff;

    assign ring_en  = la3_data_in[0];
    assign cnt_en   = la3_data_in[1];
    assign cnt_clr  = la3_data_in[2];
    assign load     = la3_data_in[3];
    assign ring_sel = la3_data_in[8:4];
    assign out_sel  = la3_data_in[13:9];

    assign chain_out = sum_q[out_sel];

    always_comb begin
        a_eff = a_q;
        if (ring_en) begin
            a_eff[ring_sel] = ~chain_out;
        end
    end

    // Each prefix level lives in its own generate scope so every level is a distinct net.
    for (genvar l = 0; l < 6; l++) begin : lvl
        logic [31:0] g;
        logic [31:0] p;
        if (l == 0) begin : base
            assign g = a_eff & b_q;
            assign p = a_eff ^ b_q;
        end else begin : comb
            for (genvar i = 0; i < 32; i++) begin : bitn
                if (((i >> (l - 1)) & 1) == 1) begin : join_blk
                    localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
                    assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[J]);
                    assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[J];
                end else begin : pass_blk
                    assign g[i] = lvl[l-1].g[i];
                    assign p[i] = lvl[l-1].p[i];
                end
            end
        end
    end

    // Carry-in is zero, so the carry into bit i is the group generate of bits i-1..0.
    assign sum_d   = lvl[0].p ^ {lvl[5].g[30:0], 1'b0};
    assign carry_d = lvl[5].g[31];

    assign a_d = load ? la1_data_in : a_q;
    assign b_d = load ? la2_data_in : b_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en && chain_out && !chain_prev_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            chain_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else if (active) begin
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            chain_prev_q <= chain_out;
            cnt_q        <= cnt_d;
        end
    end

    assign la1_data_out = active ? sum_q : '0;
    assign la2_data_out = active ? cnt_q : '0;
    assign la3_data_out = active ? {30'b0, carry_q, chain_out} : '0;
    assign io_out       = active ? {29'b0, chain_out, 8'b0} : '0;
    assign io_oeb       = active ? 38'h3F_FFFF_FEFF : {38{1'b1}};

    wire unused_ok = ^{la1_oenb, la2_oenb, la3_oenb, io_in, la3_data_in[31:14], lvl[5].p};

endmodule

// File: tb/tb_instr_adder_sklansky_wrap.sv
// Directed and randomized checks of the instrumented adder wrapper against a cycle-level
// arithmetic model of the registers it should hold.
module tb_instr_adder_sklansky_wrap;

    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic [31:0] oenb1, oenb2, oenb3;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    instr_adder_sklansky_wrap_if bus ();

    always #5 clk = ~clk;

    instr_adder_sklansky_wrap dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .active       (active),
        .la1_data_in  (bus.la1_data_in),
        .la2_data_in  (bus.la2_data_in),
        .la3_data_in  (bus.la3_data_in),
        .la1_oenb     (oenb1),
        .la2_oenb     (oenb2),
        .la3_oenb     (oenb3),
        .io_in        (io_in),
        .la1_data_out (bus.la1_data_out),
        .la2_data_out (bus.la2_data_out),
        .la3_data_out (bus.la3_data_out),
        .io_out       (io_out),
        .io_oeb       (io_oeb)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: operands, 33-bit sum, previous chain bit, edge counter.
    logic [31:0] m_a, m_b, m_cnt;
    logic [32:0] m_sum;
    logic        m_prev;

    function automatic logic [31:0] mk_ctrl(input logic ring_en, input logic cnt_en,
                                            input logic cnt_clr, input logic load,
                                            input logic [4:0] ring_sel, input logic [4:0] out_sel);
        return {18'h0, out_sel, ring_sel, load, cnt_clr, cnt_en, ring_en};
    endfunction

    function automatic logic model_chain();
        logic [4:0] osel;
        osel = bus.la3_data_in[13:9];
        return m_sum[osel];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        logic [31:0] ctrl;
        logic [31:0] a_eff;
        logic        chain;
        logic [4:0]  rsel;
        ctrl = bus.la3_data_in;
        if (rst) begin
            m_a = '0; m_b = '0; m_sum = '0; m_prev = 1'b0; m_cnt = '0;
        end else if (active) begin
            chain = model_chain();
            a_eff = m_a;
            rsel  = ctrl[8:4];
            if (ctrl[0]) a_eff[rsel] = ~chain;
            if (ctrl[2]) m_cnt = 32'd0;
            else if (ctrl[1] && chain && !m_prev) m_cnt = m_cnt + 32'd1;
            m_prev = chain;
            m_sum  = {1'b0, a_eff} + {1'b0, m_b};
            if (ctrl[3]) begin
                m_a = bus.la1_data_in;
                m_b = bus.la2_data_in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic chain;
        chain = model_chain();
        if (active) begin
            chk({tag, ".la1"}, 64'(bus.la1_data_out), 64'(m_sum[31:0]));
            chk({tag, ".la2"}, 64'(bus.la2_data_out), 64'(m_cnt));
            chk({tag, ".la3"}, 64'(bus.la3_data_out), 64'({30'b0, m_sum[32], chain}));
            chk({tag, ".io_out"}, 64'(io_out), 64'({29'b0, chain, 8'b0}));
            chk({tag, ".io_oeb"}, 64'(io_oeb), 64'(38'h3F_FFFF_FEFF));
        end else begin
            chk({tag, ".la1"}, 64'(bus.la1_data_out), 64'd0);
            chk({tag, ".la2"}, 64'(bus.la2_data_out), 64'd0);
            chk({tag, ".la3"}, 64'(bus.la3_data_out), 64'd0);
            chk({tag, ".io_out"}, 64'(io_out), 64'd0);
            chk({tag, ".io_oeb"}, 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        end
    endtask

    initial begin
        logic [31:0] ra, rb, held;
        logic [32:0] exp_sum;

        rst = 1'b1; active = 1'b1;
        oenb1 = '1; oenb2 = '1; oenb3 = '1; io_in = '0;
        bus.la1_data_in = 32'hDEAD_BEEF; bus.la2_data_in = 32'h1234_5678;
        bus.la3_data_in = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
        m_a = '0; m_b = '0; m_sum = '0; m_prev = 1'b0; m_cnt = '0;
        #1;
        tick(); tick();
        rst = 1'b0;
        bus.la3_data_in = '0;
        chk("reset.la1", 64'(bus.la1_data_out), 64'd0);
        chk("reset.la2", 64'(bus.la2_data_out), 64'd0);
        chk("reset.la3", 64'(bus.la3_data_out), 64'd0);
        chk("reset.io_out", 64'(io_out), 64'd0);
        chk("reset.io_oeb", 64'(io_oeb), 64'h3F_FFFF_FEFF);

        // All-ones plus one: sum wraps to zero with carry out.
        bus.la1_data_in = 32'hFFFF_FFFF; bus.la2_data_in = 32'd1;
        bus.la3_data_in = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
        tick();
        bus.la3_data_in = '0;
        tick();
        chk("carry.sum", 64'(bus.la1_data_out), 64'd0);
        chk("carry.cout", 64'(bus.la3_data_out[1]), 64'd1);
        check_all("carry");

        // Ring through the low five carry stages.
        bus.la1_data_in = 32'd0; bus.la2_data_in = 32'h1F;
        bus.la3_data_in = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd5);
        tick();
        bus.la3_data_in = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
        tick();
        bus.la3_data_in = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
        tick();
        bus.la3_data_in = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("ring");
        end
        chk("ring.cnt_range", 64'(bus.la2_data_out >= 32'd9 && bus.la2_data_out <= 32'd11), 64'd1);

        bus.la3_data_in = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
        tick();
        chk("clr.cnt", 64'(bus.la2_data_out), 64'd0);
        bus.la3_data_in = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5);
        for (int i = 0; i < 10; i++) tick();
        chk("clr.resume", 64'(bus.la2_data_out >= 32'd4 && bus.la2_data_out <= 32'd6), 64'd1);
        check_all("clr");

        held = m_cnt;
        active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("parked");
        end
        active = 1'b1;
        #1;
        chk("resume.held", 64'(bus.la2_data_out), 64'(held));
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("resume");
        end

        // Random operands, ring off.
        for (int v = 0; v < 1000; v++) begin
            ra = $urandom; rb = $urandom;
            if (v == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
            if (v == 1) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
            bus.la1_data_in = ra; bus.la2_data_in = rb;
            bus.la3_data_in = mk_ctrl(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
            bus.la1_data_in = $urandom; bus.la2_data_in = $urandom;
            bus.la3_data_in[3] = 1'b0;
            tick();
            exp_sum = {1'b0, ra} + {1'b0, rb};
            chk("rand.add", 64'({bus.la3_data_out[1], bus.la1_data_out}), 64'(exp_sum));
            if (v % 50 == 0) check_all("rand.state");
        end

        // Random control mixes with the ring engaged.
        for (int i = 0; i < 300; i++) begin
            bus.la1_data_in = $urandom; bus.la2_data_in = $urandom;
            bus.la3_data_in = mk_ctrl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                      1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            active = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
            check_all("rand.ring");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
